// File: rtl/riscv_register_file.sv
// riscv_register_file: 32x32 integer register file, two async read ports, one write port, x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module riscv_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_index,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_index1,
  input  logic [ADDR_WIDTH-1:0] read_index2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_en;
  assign wr_en = reg_write && (write_index != '0);
  always_ff @(posedge clk) begin
    if (nRST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[write_index] <= write_data;
    end
  end
`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1 = !nRST && wr_en && (read_index1 == write_index);
  assign fwd2 = !nRST && wr_en && (read_index2 == write_index);
  always_comb begin
    read_data1 = (read_index1 == '0) ? '0 : fwd1 ? write_data : regs[read_index1];
    read_data2 = (read_index2 == '0) ? '0 : fwd2 ? write_data : regs[read_index2];
  end
`else
  always_comb begin
    read_data1 = (read_index1 == '0) ? '0 : regs[read_index1];
    read_data2 = (read_index2 == '0) ? '0 : regs[read_index2];
  end
`endif
endmodule

// File: tb/tb_riscv_register_file.sv
// tb_riscv_register_file: directed + randomized check of riscv_register_file against an array model.
module tb_riscv_register_file;
  logic        clk = 1'b0;
  logic        nRST = 1'b1;
  logic        reg_write = 1'b0;
  logic [4:0]  write_index = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_index1 = '0;
  logic [4:0]  read_index2 = '0;
  logic [31:0] read_data1, read_data2;
  logic [31:0] model [32];
  int          vectors = 0;
  int          errors = 0;
  riscv_register_file dut (
    .clk(clk), .nRST(nRST), .reg_write(reg_write), .write_index(write_index),
    .write_data(write_data), .read_index1(read_index1), .read_index2(read_index2),
    .read_data1(read_data1), .read_data2(read_data2)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] expect_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (!nRST && reg_write && write_index != 5'd0 && idx == write_index) return write_data;
`endif
    return model[idx];
  endfunction
  task automatic cycle(input logic rst, input logic we, input logic [4:0] wi, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    nRST = rst; reg_write = we; write_index = wi; write_data = wd;
    read_index1 = r1; read_index2 = r2;
    #1;
    check("rd1", read_data1, expect_rd(r1));
    check("rd2", read_data2, expect_rd(r2));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (we && wi != 5'd0) model[wi] = wd;
    #1;
  endtask
  task automatic peek(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] e1, input logic [31:0] e2);
    nRST = 1'b0; reg_write = 1'b0; read_index1 = r1; read_index2 = r2;
    #1;
    check({tag, "_a"}, read_data1, e1);
    check({tag, "_b"}, read_data2, e2);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) peek("reset", 5'(i), 5'(31 - i), 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 5'd1, 32'hAAAAAAAA, 5'd1, 5'd1);
    peek("gated", 5'd1, 5'd0, 32'd0, 32'd0);
    cycle(1'b0, 1'b1, 5'd1, 32'hAAAAAAAA, 5'd2, 5'd3);
    peek("write", 5'd0, 5'd1, 32'd0, 32'hAAAAAAAA);
    cycle(1'b0, 1'b1, 5'd1, 32'hAAAAAAAF, 5'd4, 5'd5);
    peek("overwrite", 5'd1, 5'd1, 32'hAAAAAAAF, 32'hAAAAAAAF);
    cycle(1'b0, 1'b1, 5'd2, 32'hFACEAAAA, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd4, 32'hAAAAFACE, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd8, 32'hAAFACEAA, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd16, 32'hFAAAAACE, 5'd0, 5'd0);
    peek("multi_2_4", 5'd2, 5'd4, 32'hFACEAAAA, 32'hAAAAFACE);
    peek("multi_8_16", 5'd8, 5'd16, 32'hAAFACEAA, 32'hFAAAAACE);
    peek("x1_kept", 5'd1, 5'd3, 32'hAAAAAAAF, 32'd0);
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    peek("x0", 5'd0, 5'd0, 32'd0, 32'd0);
    nRST = 1'b0; reg_write = 1'b1; write_index = 5'd3; write_data = 32'h12345678;
    read_index1 = 5'd3; read_index2 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cyc", read_data1, 32'h12345678);
`else
    check("same_cyc", read_data1, 32'd0);
`endif
    @(posedge clk); model[3] = 32'h12345678; #1;
    peek("after_wr", 5'd3, 5'd3, 32'h12345678, 32'h12345678);
    cycle(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd2);
    peek("rst_prio", 5'd3, 5'd2, 32'd0, 32'd0);
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wi, r1, r2;
      wi = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      cycle($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, wi, $urandom, r1, r2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
